// File: rtl/mult_seq_if.sv
// Handshake and shared-adder bus for the sequential multiplier.
// mult_seq uses the slave modport. The master side is the execute stage
// plus the external adder, which drives add_sum.
interface mult_seq_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] product;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;

  modport master (
    output start, a, b, add_sum,
    input  busy, done, product, add_a, add_b
  );

  modport slave (
    input  start, a, b, add_sum,
    output busy, done, product, add_a, add_b
  );
endinterface

// File: rtl/mult_seq.sv
// Multi-cycle unsigned shift-and-add multiplier.
// It time-shares one external WIDTH-bit adder and returns the low WIDTH bits of a*b.
// Optional macro MULT_SEQ_EARLY_TERM_EN: leave RUN as soon as no multiplier
// bits remain. The product value is the same with or without the macro.
//
// state | meaning
// IDLE  | waiting for start; adder inputs parked at zero
// RUN   | one multiplier bit per cycle; accumulator fed from add_sum
// DONE  | one-cycle done pulse; start here begins the next op back-to-back
module mult_seq #(
  parameter int WIDTH = 64
) (
  input logic         clk,
  input logic         reset,
  mult_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] acc_nxt;
  logic             accept;
  logic             last_iter;

  // The accumulator only takes the adder result when the current multiplier bit is set.
  assign acc_nxt = mplier[0] ? bus.add_sum : acc;
  assign accept  = bus.start && ((state == IDLE) || (state == DONE));

`ifdef MULT_SEQ_EARLY_TERM_EN
  assign last_iter = (count == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
`else
  assign last_iter = (count == CNT_W'(WIDTH - 1));
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state. The adder inputs are parked
  // at zero outside RUN so the adder is free for other users.
  always_comb begin
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    bus.add_a = '0;
    bus.add_b = '0;
    case (state)
      RUN: begin
        bus.busy  = 1'b1;
        bus.add_a = acc;
        bus.add_b = mcand;
      end
      DONE:    bus.done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load operands on accept, iterate in RUN, capture the product on exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      count       <= '0;
      bus.product <= '0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= bus.a;
      mplier <= bus.b;
      count  <= '0;
    end else if (state == RUN) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CNT_W'(1);
      if (last_iter) bus.product <= acc_nxt;
    end
  end
endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq. The bench also acts as the external adder.
// Results are compared against a plain-arithmetic reference model.
module tb_mult_seq;
  localparam int WIDTH = 64;
`ifdef MULT_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;

  mult_seq_if #(.WIDTH(WIDTH)) bus ();

  mult_seq #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.add_sum = bus.add_a + bus.add_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic int exp_lat(input logic [63:0] b);
    int hb = 1;
    for (int i = 0; i < WIDTH; i++) if (b[i]) hb = i + 1;
    return EARLY ? hb : WIDTH;
  endfunction

  task automatic launch(input logic [63:0] a, input logic [63:0] b);
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
  endtask

  // Called at a negedge after launch. Returns at the negedge inside the done cycle.
  task automatic wait_done(input logic [63:0] a, input logic [63:0] b, input int ign_at);
    int lat = 0;
    logic [63:0] mask;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = {$urandom, $urandom};
    bus.b = {$urandom, $urandom};
    while (bus.done !== 1'b1 && lat < WIDTH + 3) begin
      mask = (lat >= 64) ? '1 : ((64'd1 << lat) - 64'd1);
      chk("busy_run", {63'd0, bus.busy}, 64'd1);
      chk("add_a_run", bus.add_a, a * (b & mask));
      chk("add_b_run", bus.add_b, a << lat);
      if (lat == ign_at) begin
        bus.start = 1'b1;
        bus.a = 64'd1;
        bus.b = 64'd1;
      end else if (lat == ign_at + 1) begin
        bus.start = 1'b0;
      end
      lat++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_seen", {63'd0, bus.done}, 64'd1);
    chk("latency", 64'(lat), 64'(exp_lat(b)));
    chk("product", bus.product, a * b);
    chk("busy_done", {63'd0, bus.busy}, 64'd0);
    chk("add_a_done", bus.add_a, 64'd0);
    chk("add_b_done", bus.add_b, 64'd0);
  endtask

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input int ign_at);
    launch(a, b);
    wait_done(a, b, ign_at);
    @(negedge clk);
    chk("done_pulse", {63'd0, bus.done}, 64'd0);
    chk("product_hold", bus.product, a * b);
  endtask

  initial begin
    int t1;
    int seen;
    logic [63:0] ra;
    logic [63:0] rb;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_product", bus.product, 64'd0);
    chk("rst_add_a", bus.add_a, 64'd0);
    chk("rst_add_b", bus.add_b, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(64'd3, 64'd5, -1);
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, -1);
    run_op(64'h8000_0000_0000_0000, 64'd2, -1);
    run_op(64'd7, 64'd9, 10);
    run_op(64'd7, 64'd1, -1);
    run_op(64'd5, 64'd0, -1);
    run_op(64'd3, 64'h8000_0000_0000_0000, -1);

    // Reset during an operation
    launch(64'd6, 64'd7);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (29) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
    chk("midrst_done", {63'd0, bus.done}, 64'd0);
    chk("midrst_product", bus.product, 64'd0);
    chk("midrst_add_a", bus.add_a, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (70) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    chk("midrst_no_done", 64'(seen), 64'd0);
    run_op(64'd4, 64'd4, -1);

    // Back-to-back: start is held through the DONE cycle
    launch(64'd11, 64'd13);
    wait_done(64'd11, 64'd13, -1);
    t1 = cyc;
    launch(64'd10, 64'd10);
    wait_done(64'd10, 64'd10, -1);
    chk("b2b_spacing", 64'(cyc - t1), 64'(exp_lat(64'd10) + 1));
    @(negedge clk);
    chk("b2b_idle", {63'd0, bus.busy}, 64'd0);

    for (int k = 0; k < 20; k++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rb = rb >> $urandom_range(0, 63);
      run_op(ra, rb, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Multi-cycle unsigned shift-and-add multiplier controller that time-shares one external WIDTH-bit ripple adder (the ALU adder64 instance).
- Sequences operand registers, drives the adder inputs, and captures the adder sum once per cycle.
- Returns the low WIDTH bits of A*B, matching MUL semantics.
- Sits beside the ALU in the execute stage; the pipeline stalls on busy.

Parameters:
WIDTH, 64, operand/product width; must match the attached adder width
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge
A  input  WIDTH  multiplicand; captured when start is accepted
B  input  WIDTH  multiplier; captured when start is accepted
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; product valid
product  output  WIDTH  low WIDTH bits of A*B; held until next accepted start
add_a  output  WIDTH  adder operand A (accumulator)
add_b  output  WIDTH  adder operand B (shifted multiplicand)
add_sum  input  WIDTH  combinational sum from external adder, (add_a+add_b) mod 2^WIDTH

Behaviour:
- Clock/reset decided: one clock clk; reset is asynchronous, active-high.
- Reset, including mid-operation: state=IDLE; busy=0, done=0, product=0, internal acc/mcand/mplier/count=0, add_a=add_b=0. Any in-flight op is discarded; no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 at edge -> mcand<=A, mplier<=B, acc<=0, count<=0, state RUN.
- RUN, one iteration per edge:
  - if mplier[0]=1, acc<=add_sum; else acc unchanged.
  - mcand<=mcand<<1 (MSB discarded); mplier<=mplier>>1 (logical); count<=count+1.
  - When count=WIDTH-1 at the edge, move to DONE and load product with the final acc value (add_sum if mplier[0]=1, else acc).
- DONE: lasts exactly one cycle, done=1.
  - start=1 at this edge is accepted: load as in IDLE, go to RUN (back-to-back).
  - Else go to IDLE.
- busy = (state==RUN). done = (state==DONE). Both decoded from registered state, so glitch-free.
- add_a=acc and add_b=mcand in RUN. Both forced to 0 in IDLE/DONE so the shared adder is free for other use.
- start in RUN is ignored; no queuing. A/B may change freely after acceptance.
- Latency: start accepted at edge N -> done=1 in the cycle following edge N+WIDTH; busy high for WIDTH cycles.
- Arithmetic: unsigned, modulo 2^WIDTH; overflow bits silently dropped. Two's-complement low bits are therefore also correct for signed operands.
- product changes only at the RUN->DONE transition or on reset.

Optional Feature:
- Macro: MULT_SEQ_EARLY_TERM_EN.
- Defined: RUN also exits to DONE at an edge where the next mplier value (mplier>>1) is 0, i.e. no remaining 1 bits. B=0 takes one iteration. Latency becomes max(1, index of highest set bit of B + 1) cycles.
- Undefined: fixed WIDTH iterations regardless of operands.
- Product value is identical in both builds.

Test Plan:
- Reset, then start with A=3, B=5 -> busy for 64 cycles, done pulse one cycle, product=15; add_a/add_b=0 after done.
- A=64'hFFFF_FFFF_FFFF_FFFF, B=2 -> product=64'hFFFF_FFFF_FFFF_FFFE; A=2^63, B=2 -> product=0 (overflow truncated).
- Start A=7, B=9; pulse start with A=1, B=1 at cycle 10 of RUN -> ignored, product=63.
- Assert reset at cycle 30 of an op with A=6, B=7 -> busy=0, product=0 immediately; no done pulse; a fresh start with A=4, B=4 -> product=16 after 64 cycles.
- Hold start high through the DONE cycle with next A=10, B=10 -> second op starts with no IDLE gap; two done pulses 65 cycles apart; products 100 after 10*10 and correct first result.
- With MULT_SEQ_EARLY_TERM_EN: A=7, B=1 -> done after 1 RUN cycle, product=7. A=5, B=0 -> product=0 after 1 cycle. A=3, B=2^63 -> 64 cycles, product=2^63.
